// File: rtl/vector_construction.sv
// Packs six asynchronous switch inputs into a registered LED vector.
// Each bit is synchronized, optionally debounced, then registered onto led.
module vector_construction #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0,
   parameter bit REVERSE         = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       switch0,
   input  logic       switch1,
   input  logic       switch2,
   input  logic       switch3,
   input  logic       switch4,
   input  logic       switch5,
   output logic [5:0] led
);

   logic [5:0]                  raw;
   logic [SYNC_STAGES-1:0][5:0] sync_q;
   logic [5:0]                  sync_bit;
   logic [5:0]                  accepted;
   logic [5:0]                  led_q;

   generate
      if (REVERSE) begin : g_rev
         assign raw = {switch0, switch1, switch2, switch3, switch4, switch5};
      end else begin : g_fwd
         assign raw = {switch5, switch4, switch3, switch2, switch1, switch0};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= raw;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign sync_bit = sync_q[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign accepted = sync_bit;
      end else begin : g_debounce
         localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

         logic [5:0]       acc_q, acc_d;
         logic [5:0][15:0] cnt_q, cnt_d;

         // A bit is accepted only after it differs from acc_q for DEBOUNCE_CYCLES edges in a row.
         always_comb begin
            acc_d = acc_q;
            cnt_d = cnt_q;
            for (int b = 0; b < 6; b++) begin
               if (sync_bit[b] == acc_q[b]) begin
                  cnt_d[b] = '0;
               end else if (cnt_q[b] == CNT_LAST) begin
                  acc_d[b] = sync_bit[b];
                  cnt_d[b] = '0;
               end else if (cnt_q[b] != 16'hFFFF) begin
                  cnt_d[b] = cnt_q[b] + 16'd1;
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               acc_q <= '0;
               cnt_q <= '0;
            end else begin
               acc_q <= acc_d;
               cnt_q <= cnt_d;
            end
         end

         assign accepted = acc_q;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_q <= '0;
      end else begin
         led_q <= accepted;
      end
   end

   assign led = led_q;

endmodule

// File: tb/tb_vector_construction.sv
// Directed bench for vector_construction: default, REVERSE=1 and DEBOUNCE_CYCLES=4 instances.
module tb_vector_construction;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] sw = 6'b0;
   logic [5:0] led_def, led_rev, led_db;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   vector_construction u_def (
      .clk(clk), .rst_n(rst_n),
      .switch0(sw[0]), .switch1(sw[1]), .switch2(sw[2]),
      .switch3(sw[3]), .switch4(sw[4]), .switch5(sw[5]),
      .led(led_def)
   );

   vector_construction #(.REVERSE(1'b1)) u_rev (
      .clk(clk), .rst_n(rst_n),
      .switch0(sw[0]), .switch1(sw[1]), .switch2(sw[2]),
      .switch3(sw[3]), .switch4(sw[4]), .switch5(sw[5]),
      .led(led_rev)
   );

   vector_construction #(.DEBOUNCE_CYCLES(4)) u_db (
      .clk(clk), .rst_n(rst_n),
      .switch0(sw[0]), .switch1(sw[1]), .switch2(sw[2]),
      .switch3(sw[3]), .switch4(sw[4]), .switch5(sw[5]),
      .led(led_db)
   );

   typedef struct {
      logic [5:0] sw;
      logic [5:0] exp_def;
      logic [5:0] exp_rev;
   } vec_t;

   vec_t tbl [10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   initial begin
      logic [5:0] prev;
      logic       seen_bad;

      tbl[0] = '{6'b000001, 6'b000001, 6'b100000};
      tbl[1] = '{6'b000010, 6'b000010, 6'b010000};
      tbl[2] = '{6'b000100, 6'b000100, 6'b001000};
      tbl[3] = '{6'b001000, 6'b001000, 6'b000100};
      tbl[4] = '{6'b010000, 6'b010000, 6'b000010};
      tbl[5] = '{6'b100000, 6'b100000, 6'b000001};
      tbl[6] = '{6'b000000, 6'b000000, 6'b000000};
      tbl[7] = '{6'b111111, 6'b111111, 6'b111111};
      tbl[8] = '{6'b110011, 6'b110011, 6'b110011};
      tbl[9] = '{6'b101100, 6'b101100, 6'b001101};

      // Reset held with all switches high
      rst_n = 1'b0;
      sw    = 6'b111111;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("reset_hold", led_def, 6'b000000);
      end
      rst_n = 1'b1;
      tick();
      tick();
      chk("reset_release_2", led_def, 6'b000000);
      tick();
      chk("reset_release_3", led_def, 6'b111111);

      // Table-driven mapping, both bit orderings
      for (int t = 0; t < 10; t++) begin
         sw = tbl[t].sw;
         tick(); tick(); tick();
         chk("map_default", led_def, tbl[t].exp_def);
         chk("map_reverse", led_rev, tbl[t].exp_rev);
      end

      // Exhaustive count up 0..63 then wrap to 0, checking exact latency
      sw = 6'd0;
      for (int i = 0; i < 10; i++) tick();
      prev = 6'd0;
      for (int v = 0; v <= 64; v++) begin
         sw = (v == 64) ? 6'd0 : 6'(v);
         tick(); tick();
         chk("count_latency_2", led_def, prev);
         tick();
         chk("count_value", led_def, sw);
         for (int i = 0; i < 7; i++) tick();
         prev = sw;
      end

      // Async reset between edges, release with a new pattern
      sw = 6'b101010;
      tick(); tick(); tick();
      chk("pre_async_reset", led_def, 6'b101010);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_immediate", led_def, 6'b000000);
      sw = 6'b010101;
      tick();
      rst_n = 1'b1;
      seen_bad = 1'b0;
      tick();
      if (led_def == 6'b101010) seen_bad = 1'b1;
      chk("async_release_1", led_def, 6'b000000);
      tick();
      if (led_def == 6'b101010) seen_bad = 1'b1;
      chk("async_release_2", led_def, 6'b000000);
      tick();
      chk("async_release_3", led_def, 6'b010101);
      chk("async_no_stale", {5'b0, seen_bad}, 6'b000000);

      // Stability: constant inputs for 100 cycles
      sw = 6'b110011;
      tick(); tick(); tick();
      for (int i = 0; i < 100; i++) begin
         tick();
         chk("stable", led_def, 6'b110011);
      end

      // Debounce instance: 2-cycle glitch rejected, long hold accepted
      rst_n = 1'b0;
      sw    = 6'b000000;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      chk("db_idle", led_db, 6'b000000);
      sw = 6'b000100;
      tick(); tick();
      sw = 6'b000000;
      seen_bad = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (led_db != 6'b000000) seen_bad = 1'b1;
      end
      chk("db_glitch_rejected", {5'b0, seen_bad}, 6'b000000);
      sw = 6'b000100;
      for (int i = 0; i < 6; i++) tick();
      chk("db_hold_6", led_db, 6'b000000);
      tick();
      chk("db_hold_7", led_db, 6'b000100);
      for (int i = 0; i < 3; i++) tick();
      chk("db_hold_10", led_db, 6'b000100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vector_construction.md
Name: vector_construction

Overview:
- Packs six independent single-bit switch inputs into one 6-bit LED vector, led[5:0] = {switch5, switch4, switch3, switch2, switch1, switch0}.
- Sits between board slide switches and the LED bank.
- Each switch passes through a synchronizer and an optional debouncer, then a registered output stage, so led is glitch-free and aligned to clk.

Parameters:
- SYNC_STAGES, 2: flip-flop stages per switch synchronizer; legal range 1..4.
- DEBOUNCE_CYCLES, 0: consecutive stable cycles required before a synchronized bit is accepted; 0 bypasses the debouncer. Legal range 0..65535.
- REVERSE, 0: bit ordering. 0 gives led[i] = switch_i. 1 gives led[i] = switch_(5-i).

Ports:
- clk, input, 1: system clock; all state is on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- switch0, input, 1: switch 0, asynchronous to clk.
- switch1, input, 1: switch 1, asynchronous to clk.
- switch2, input, 1: switch 2, asynchronous to clk.
- switch3, input, 1: switch 3, asynchronous to clk.
- switch4, input, 1: switch 4, asynchronous to clk.
- switch5, input, 1: switch 5, asynchronous to clk.
- led, output, 6: registered packed vector of the switch states.

Behaviour:
- Reset: rst_n low immediately clears all synchronizer flops, debounce counters, accepted-state registers and led to 6'b000000.
  - Reset is asynchronous on assertion and independent of clk.
  - Deassertion is sampled on the next rising clk edge.
- Packing: the raw vector is {switch5..switch0} (switch5 is the MSB) when REVERSE=0, and {switch0..switch5} when REVERSE=1.
  - Each bit is processed independently.
  - There is no arithmetic and no cross-bit interaction.
- Synchronizer: each bit goes through a chain of SYNC_STAGES flops.
- Debounce (DEBOUNCE_CYCLES=N>0), per bit:
  - Keep an accepted state and a 16-bit counter.
  - If the synchronized bit equals the accepted state, clear the counter.
  - Otherwise increment the counter. When the counter reaches N-1 and the bit still differs, update the accepted state and clear the counter.
  - Any return to the accepted value before that point clears the counter; the glitch is discarded.
- Debounce bypass (N=0): the accepted state is the synchronized bit directly, with no extra register.
- Output register: led <= accepted vector every clk.
- Latency:
  - With N=0, a switch change reaches led SYNC_STAGES+1 rising edges after it is first sampled.
  - With N>0, it reaches led SYNC_STAGES+N+1 edges after it is first sampled.
  - With defaults (SYNC_STAGES=2, N=0) this is 3 cycles.
- Simultaneous changes: multiple switches changing on the same edge appear on led on the same cycle. Example: all six rising gives led 000000 -> 111111 in one step.
- Wrap-around: a 63 -> 0 transition of the switch vector (111111 -> 000000) propagates like any other value, with no intermediate codes at the output when all bits share the same latency.
- Reset mid-operation: led returns to 000000 at once. After release the pipeline refills and led shows the current switches after the full latency. No stale pre-reset value may ever appear.
- Inputs held constant: led stays constant and never toggles.
- Counters saturate and never wrap (16-bit width covers the full legal range).

Test Plan:
- Reset: hold rst_n=0 with all switches=1 for 5 cycles -> led=000000 throughout. Release -> led=111111 exactly 3 cycles after the first sampling edge (defaults).
- Exhaustive count: drive {switch5..switch0} from 0 to 63 and back to 0, one value per 10 cycles (defaults) -> 3 cycles after each change, led equals the driven value, including the 63 -> 0 wrap.
- Single-bit mapping: set only switch5=1 -> led=100000. Repeat with REVERSE=1 -> led=000001. Repeat for each bit index.
- Debounce, DEBOUNCE_CYCLES=4: pulse switch2 high for 2 cycles -> led stays 000000. Hold it high for 10 cycles -> led=000100 after SYNC_STAGES+5 edges.
- Async reset mid-stream: with led=101010, pull rst_n low between clock edges -> led=000000 before the next edge. Release with switches=010101 -> led=010101 after 3 cycles, with no 101010 in between.
- Stability: hold switches at 110011 for 100 cycles -> led constant at 110011 with no toggles.
